// File: rtl/adder_carry_save.sv
// ----------------------------------------------------------------------------
// adder_carry_save
//   Width-parameterised 3:2 carry-save compressor (one full adder per bit)
//   with an optional single output register stage. Reduces three operands to
//   a sum/carry pair with no carry propagation between bit positions:
//       opA + opB + opC == res + (car << 1)   (unsigned, exact)
//   The carry vector is presented unshifted; the consumer applies the shift.
//
// Parameters
//   width_p    : operand width in bits (>= 1)
//   pipeline_p : 0 = combinational outputs, zero latency
//                1 = outputs registered once, 1-cycle latency
//
// Ports
//   clk_i    in   1          clock (unused when pipeline_p=0)
//   reset_i  in   1          synchronous active-low reset (unused when pipeline_p=0)
//   v_i      in   1          input operands valid
//   opA_i    in   width_p    operand A
//   opB_i    in   width_p    operand B
//   opC_i    in   width_p    operand C
//   res_o    out  width_p    sum bits, bit i has weight 2^i
//   car_o    out  width_p    carry bits, bit i has weight 2^(i+1)
//   v_o      out  1          output valid
//   sum_o    out  width_p+2  resolved sum res + (car<<1)
//                            (only with ADDER_CARRY_SAVE_SUM_EN defined)
//
// Configuration macro
//   ADDER_CARRY_SAVE_SUM_EN : adds sum_o and its carry-propagate adder.
// ----------------------------------------------------------------------------
module adder_carry_save #(
    parameter int unsigned width_p    = 32,
    parameter int unsigned pipeline_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] opA_i,
    input  logic [width_p-1:0] opB_i,
    input  logic [width_p-1:0] opC_i,
    output logic [width_p-1:0] res_o,
    output logic [width_p-1:0] car_o,
    output logic               v_o
`ifdef ADDER_CARRY_SAVE_SUM_EN
    ,
    output logic [width_p+1:0] sum_o
`endif
);

    localparam int unsigned SUM_W = width_p + 2;

    logic [width_p-1:0] res_c;
    logic [width_p-1:0] car_c;

    // Full-adder array: parity gives the sum bit, majority gives the carry bit.
    always_comb begin
        res_c = opA_i ^ opB_i ^ opC_i;
        car_c = (opA_i & opB_i) | (opA_i & opC_i) | (opB_i & opC_i);
    end

    generate
        if (pipeline_p == 0) begin : g_comb
            // No state: clock and reset are intentionally unused in this mode.
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ reset_i;

            assign res_o = res_c;
            assign car_o = car_c;
            assign v_o   = v_i;
        end else begin : g_pipe
            logic [width_p-1:0] res_q;
            logic [width_p-1:0] car_q;
            logic               v_q;

            // Output stage: reset wins over valid; idle cycles hold the last result.
            always_ff @(posedge clk_i) begin
                if (!reset_i) begin
                    res_q <= '0;
                    car_q <= '0;
                    v_q   <= 1'b0;
                end else begin
                    if (v_i) begin
                        res_q <= res_c;
                        car_q <= car_c;
                    end
                    v_q <= v_i;
                end
            end

            assign res_o = res_q;
            assign car_o = car_q;
            assign v_o   = v_q;
        end
    endgenerate

`ifdef ADDER_CARRY_SAVE_SUM_EN
    // Resolved from the output res/car so it shares their timing, reset and hold.
    assign sum_o = SUM_W'(res_o) + SUM_W'({car_o, 1'b0});
`endif

endmodule

// File: tb/tb_adder_carry_save.sv
// ----------------------------------------------------------------------------
// tb_adder_carry_save
//   Scoreboard bench for adder_carry_save. Six instances cover widths 1, 8 and
//   33 in both pipeline modes, all fed from one shared 33-bit stimulus stream
//   (each instance sees the low bits it needs). The driver pushes expected
//   results into per-instance queues; a monitor pops and compares whenever an
//   instance raises v_o, and checks that idle pipelined outputs hold.
//   Build with ADDER_CARRY_SAVE_SUM_EN defined to also check sum_o.
// ----------------------------------------------------------------------------
module tb_adder_carry_save;

    typedef struct packed {
        logic [32:0] res;
        logic [32:0] car;
        logic [34:0] sum;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        v;
    logic [32:0] a;
    logic [32:0] b;
    logic [32:0] c;

    int errors;
    int checks;

    exp_t q    [6][$];
    exp_t last [6];

    // Instance k: width = {1,1,8,8,33,33}[k], pipelined when k is odd.
    function automatic int unsigned width_of(input int k);
        case (k)
            0, 1:    return 1;
            2, 3:    return 8;
            default: return 33;
        endcase
    endfunction

    // Reference: res is the bitwise parity; car is whatever makes the exact
    // arithmetic identity A+B+C == res + 2*car hold.
    function automatic exp_t model(input int unsigned w, input logic [32:0] ta,
                                   input logic [32:0] tb_, input logic [32:0] tc);
        logic [34:0] mask;
        logic [34:0] am, bm, cm, total, r;
        exp_t e;
        mask  = (35'd1 << w) - 35'd1;
        am    = {2'b00, ta} & mask;
        bm    = {2'b00, tb_} & mask;
        cm    = {2'b00, tc} & mask;
        total = am + bm + cm;
        r     = am ^ bm ^ cm;
        e.res = r[32:0];
        e.car = 33'((total - r) >> 1);
        e.sum = total;
        return e;
    endfunction

    // ---------------- DUT instances ----------------
    logic        v_1c, v_1p, v_8c, v_8p, v_33c, v_33p;
    logic [0:0]  r_1c, r_1p, c_1c, c_1p;
    logic [7:0]  r_8c, r_8p, c_8c, c_8p;
    logic [32:0] r_33c, r_33p, c_33c, c_33p;
    logic [2:0]  s_1c, s_1p;
    logic [9:0]  s_8c, s_8p;
    logic [34:0] s_33c, s_33p;

`ifndef ADDER_CARRY_SAVE_SUM_EN
    assign s_1c = '0; assign s_1p = '0;
    assign s_8c = '0; assign s_8p = '0;
    assign s_33c = '0; assign s_33p = '0;
`endif

    adder_carry_save #(.width_p(1), .pipeline_p(0)) u_1c (
        .clk_i(clk), .reset_i(rst_n), .v_i(v),
        .opA_i(a[0:0]), .opB_i(b[0:0]), .opC_i(c[0:0]),
        .res_o(r_1c), .car_o(c_1c), .v_o(v_1c)
`ifdef ADDER_CARRY_SAVE_SUM_EN
        , .sum_o(s_1c)
`endif
    );
    adder_carry_save #(.width_p(1), .pipeline_p(1)) u_1p (
        .clk_i(clk), .reset_i(rst_n), .v_i(v),
        .opA_i(a[0:0]), .opB_i(b[0:0]), .opC_i(c[0:0]),
        .res_o(r_1p), .car_o(c_1p), .v_o(v_1p)
`ifdef ADDER_CARRY_SAVE_SUM_EN
        , .sum_o(s_1p)
`endif
    );
    adder_carry_save #(.width_p(8), .pipeline_p(0)) u_8c (
        .clk_i(clk), .reset_i(rst_n), .v_i(v),
        .opA_i(a[7:0]), .opB_i(b[7:0]), .opC_i(c[7:0]),
        .res_o(r_8c), .car_o(c_8c), .v_o(v_8c)
`ifdef ADDER_CARRY_SAVE_SUM_EN
        , .sum_o(s_8c)
`endif
    );
    adder_carry_save #(.width_p(8), .pipeline_p(1)) u_8p (
        .clk_i(clk), .reset_i(rst_n), .v_i(v),
        .opA_i(a[7:0]), .opB_i(b[7:0]), .opC_i(c[7:0]),
        .res_o(r_8p), .car_o(c_8p), .v_o(v_8p)
`ifdef ADDER_CARRY_SAVE_SUM_EN
        , .sum_o(s_8p)
`endif
    );
    adder_carry_save #(.width_p(33), .pipeline_p(0)) u_33c (
        .clk_i(clk), .reset_i(rst_n), .v_i(v),
        .opA_i(a), .opB_i(b), .opC_i(c),
        .res_o(r_33c), .car_o(c_33c), .v_o(v_33c)
`ifdef ADDER_CARRY_SAVE_SUM_EN
        , .sum_o(s_33c)
`endif
    );
    adder_carry_save #(.width_p(33), .pipeline_p(1)) u_33p (
        .clk_i(clk), .reset_i(rst_n), .v_i(v),
        .opA_i(a), .opB_i(b), .opC_i(c),
        .res_o(r_33p), .car_o(c_33p), .v_o(v_33p)
`ifdef ADDER_CARRY_SAVE_SUM_EN
        , .sum_o(s_33p)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Pop-and-compare on v_o; for pipelined instances check hold when idle.
    task automatic mon(input int k, input logic vo, input logic [32:0] r,
                       input logic [32:0] cr, input logic [34:0] s);
        exp_t e;
        bit   pipe;
        pipe = (k % 2) == 1;
        if (vo === 1'b1) begin
            checks++;
            if (q[k].size() == 0) begin
                errors++;
                $display("FAIL inst%0d unexpected v_o: got 1 want no pending result", k);
            end else begin
                e = q[k].pop_front();
                if (r !== e.res || cr !== e.car
`ifdef ADDER_CARRY_SAVE_SUM_EN
                    || s !== e.sum
`endif
                   ) begin
                    errors++;
                    $display("FAIL inst%0d result: got res=%h car=%h sum=%h want res=%h car=%h sum=%h",
                             k, r, cr, s, e.res, e.car, e.sum);
                end
                if (pipe) last[k] = e;
            end
        end else if (vo !== 1'b0) begin
            chk($sformatf("inst%0d v_o known", k), 35'(vo), 35'd0);
        end else if (pipe) begin
            checks++;
            if (r !== last[k].res || cr !== last[k].car
`ifdef ADDER_CARRY_SAVE_SUM_EN
                || s !== last[k].sum
`endif
               ) begin
                errors++;
                $display("FAIL inst%0d hold: got res=%h car=%h want res=%h car=%h",
                         k, r, cr, last[k].res, last[k].car);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, v_1c,  33'(r_1c),  33'(c_1c),  35'(s_1c));
        mon(1, v_1p,  33'(r_1p),  33'(c_1p),  35'(s_1p));
        mon(2, v_8c,  33'(r_8c),  33'(c_8c),  35'(s_8c));
        mon(3, v_8p,  33'(r_8p),  33'(c_8p),  35'(s_8p));
        mon(4, v_33c, r_33c,      c_33c,      35'(s_33c));
        mon(5, v_33p, r_33p,      c_33p,      35'(s_33p));
    end

    // ---------------- driver ----------------
    task automatic step(input logic [32:0] ta, input logic [32:0] tb_, input logic [32:0] tc,
                        input logic tv, input logic tr);
        bit pipe;
        @(negedge clk);
        a = ta; b = tb_; c = tc; v = tv; rst_n = tr;
        for (int k = 0; k < 6; k++) begin
            pipe = (k % 2) == 1;
            if (tv && (!pipe || tr)) q[k].push_back(model(width_of(k), ta, tb_, tc));
            if (pipe && !tr) last[k] = '0;
        end
    endtask

    function automatic logic [32:0] rand_op();
        logic [32:0] x;
        case ($urandom_range(0, 15))
            0:       x = '1;
            1:       x = '0;
            default: x = 33'({$urandom(), $urandom()});
        endcase
        return x;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        for (int k = 0; k < 6; k++) last[k] = '0;
        rst_n = 1'b0; v = 1'b0; a = '0; b = '0; c = '0;

        // Reset state of the registered instances.
        step('0, '0, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("reset v_o w8",  35'(v_8p), 35'd0);
        chk("reset res w8",  35'(r_8p), 35'd0);
        chk("reset car w33", 35'(c_33p), 35'd0);
        chk("reset v_o w1",  35'(v_1p), 35'd0);

        // Directed vectors back to back; width-8 combinational outputs against fixed values.
        step(33'h0FF, 33'h001, 33'h000, 1'b1, 1'b1); #1;
        chk("vec1 res w8c", 35'(r_8c), 35'h0FE);
        chk("vec1 car w8c", 35'(c_8c), 35'h001);
        step(33'h0FF, 33'h0FF, 33'h0FF, 1'b1, 1'b1); #1;
        chk("vec2 res w8c", 35'(r_8c), 35'h0FF);
        chk("vec2 car w8c", 35'(c_8c), 35'h0FF);
        step(33'h00F, 33'h033, 33'h055, 1'b1, 1'b1); #1;
        chk("vec3 res w8c", 35'(r_8c), 35'h069);
        chk("vec3 car w8c", 35'(c_8c), 35'h017);
        @(posedge clk); #2;
        chk("vec3 res w8p", 35'(r_8p), 35'h069);
        chk("vec3 car w8p", 35'(c_8p), 35'h017);
        chk("vec3 v_o w8p", 35'(v_8p), 35'd1);

        // Idle: v_o drops, registered outputs hold (also checked by the monitor).
        step('0, '1, '1, 1'b0, 1'b1);
        step('1, '0, '1, 1'b0, 1'b1);
        @(posedge clk); #2;
        chk("idle v_o w8p", 35'(v_8p), 35'd0);
        chk("idle hold res w8p", 35'(r_8p), 35'h069);

        // Reset with simultaneous valid: operands discarded, outputs cleared.
        step(33'h0FF, 33'h0FF, 33'h0FF, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("rst+v v_o w8p", 35'(v_8p), 35'd0);
        chk("rst+v res w8p", 35'(r_8p), 35'd0);
        chk("rst+v car w8p", 35'(c_8p), 35'd0);

        // First valid after reset release is delivered one cycle later.
        step(33'h0FF, 33'h001, 33'h000, 1'b1, 1'b1);
        @(posedge clk); #2;
        chk("post-rst v_o w8p", 35'(v_8p), 35'd1);
        chk("post-rst res w8p", 35'(r_8p), 35'h0FE);

        // Randomized traffic with sparse valid gaps and occasional resets.
        for (int i = 0; i < 10000; i++) begin
            step(rand_op(), rand_op(), rand_op(),
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 199) != 0);
        end

        // Drain and confirm every expected result was delivered.
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b1);
        @(posedge clk); #2;
        for (int k = 0; k < 6; k++)
            chk($sformatf("inst%0d pending results", k), 35'(q[k].size()), 35'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
